// File: rtl/ldpc_encoder_serial.sv
// rtl/ldpc_encoder_serial.sv - bit-serial systematic LDPC (11,7) encoder, valid/ready on both sides
// Optional feature macro: ERR_INJECT_EN (adds inj_mask error-injection input).
module ldpc_encoder_serial #(
  parameter int                 MSG_W = 7,
  parameter int                 CW_W  = 11,
  parameter logic [MSG_W-1:0]   ROW0  = 7'b1001010,
  parameter logic [MSG_W-1:0]   ROW1  = 7'b0101100,
  parameter logic [MSG_W-1:0]   ROW2  = 7'b0010111,
  parameter logic [MSG_W-1:0]   ROW3  = 7'b1110001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             msg_valid,
  input  logic [MSG_W-1:0] msg_data,
  output logic             msg_ready,
  output logic             cw_valid,
  output logic [CW_W-1:0]  cw_data,
  input  logic             cw_ready,
  output logic             busy
`ifdef ERR_INJECT_EN
  ,
  input  logic [CW_W-1:0]  inj_mask
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q;
  logic [MSG_W-1:0]  shift_q;
  logic [3:0]        parity_q, parity_d;
  logic [CW_W-1:0]   cw_q;
  logic [2:0]        bit_idx;
  logic [3:0]        row_bits;
  logic              last_bit;
`ifdef ERR_INJECT_EN
  logic [CW_W-1:0]   mask_q;
`endif

  // Column of H for the message bit currently at the top of the shift register.
  assign bit_idx  = 3'(MSG_W - 1) - cnt_q;
  assign row_bits = {ROW0[bit_idx], ROW1[bit_idx], ROW2[bit_idx], ROW3[bit_idx]};
  assign parity_d = parity_q ^ (row_bits & {4{shift_q[MSG_W-1]}});
  assign last_bit = (cnt_q == 3'(MSG_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (msg_valid) state_d = S_SHIFT;
      S_SHIFT: if (last_bit)  state_d = S_OUT;
      S_OUT:   if (cw_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    msg_ready = 1'b0;
    cw_valid  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE:  msg_ready = 1'b1;
      S_SHIFT: busy      = 1'b1;
      S_OUT: begin
        cw_valid = 1'b1;
        busy     = 1'b1;
      end
      default: msg_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      parity_q <= '0;
      cw_q     <= '0;
`ifdef ERR_INJECT_EN
      mask_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (msg_valid) begin
            shift_q  <= msg_data;
            cw_q     <= {msg_data, 4'b0000};
            parity_q <= '0;
            cnt_q    <= '0;
`ifdef ERR_INJECT_EN
            mask_q   <= inj_mask;
`endif
          end
        end
        S_SHIFT: begin
          parity_q <= parity_d;
          shift_q  <= shift_q << 1;
          cnt_q    <= cnt_q + 3'd1;
          if (last_bit) cw_q[3:0] <= parity_d;
        end
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef ERR_INJECT_EN
  assign cw_data = (state_q == S_OUT) ? (cw_q ^ mask_q) : cw_q;
`else
  assign cw_data = cw_q;
`endif

endmodule

// File: tb/tb_ldpc_encoder_serial.sv
// tb/tb_ldpc_encoder_serial.sv - self-checking bench for ldpc_encoder_serial
module tb_ldpc_encoder_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_valid;
  logic [6:0]  msg_data;
  logic        msg_ready;
  logic        cw_valid;
  logic [10:0] cw_data;
  logic        cw_ready;
  logic        busy;
`ifdef ERR_INJECT_EN
  logic [10:0] inj_mask;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ldpc_encoder_serial dut (
    .clk      (clk),
    .rst      (rst),
    .msg_valid(msg_valid),
    .msg_data (msg_data),
    .msg_ready(msg_ready),
    .cw_valid (cw_valid),
    .cw_data  (cw_data),
    .cw_ready (cw_ready),
    .busy     (busy)
`ifdef ERR_INJECT_EN
    ,
    .inj_mask (inj_mask)
`endif
  );

  typedef struct {
    logic [6:0]  msg;
    logic [10:0] cw;
  } vec_t;

  vec_t vecs[5];

  // Parity-check matrix rows, each over cw[10:4]; row i governs cw[3-i].
  function automatic logic [6:0] h_row(input int i);
    logic [6:0] r [4];
    r[0] = 7'b1001010;
    r[1] = 7'b0101100;
    r[2] = 7'b0010111;
    r[3] = 7'b1110001;
    return r[i];
  endfunction

  function automatic logic [10:0] encode(input logic [6:0] m);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[3-i] = ^(m & h_row(i));
    return {m, p};
  endfunction

  function automatic logic [3:0] syndrome(input logic [10:0] c);
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = (^(c[10:4] & h_row(i))) ^ c[3-i];
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [6:0] m);
    int n = 0;
    while (!msg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 50), 1);
    msg_valid = 1'b1;
    msg_data  = m;
    @(negedge clk);
    msg_valid = 1'b0;
    msg_data  = 7'($urandom);
`ifdef ERR_INJECT_EN
    inj_mask  = '0;
`endif
  endtask

  task automatic run_vec(input logic [6:0] m, input logic [10:0] exp, input string name);
    int lat = 0;
    bit rdy = 1'b0;
    send(m);
    while (!cw_valid && lat < 30) begin
      if (msg_ready) rdy = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 7);
    check({name, "_rdy_low"}, 32'(rdy), 0);
    check({name, "_rdy_out"}, 32'(msg_ready), 0);
    check({name, "_cw"}, 32'(cw_data), 32'(exp));
    cw_ready = 1'b1;
    @(negedge clk);
    cw_ready = 1'b0;
    check({name, "_vld_fall"}, 32'(cw_valid), 0);
    check({name, "_rdy_back"}, 32'(msg_ready), 1);
  endtask

  initial begin
    int lat, acc, xfers, idx, rx, cyc;
    bit stable;
    logic [10:0] cap;
    logic [6:0] exp_q[$];
    logic [6:0] em;

    vecs[0] = '{msg: 7'h00, cw: 11'h000};
    vecs[1] = '{msg: 7'h40, cw: 11'h409};
    vecs[2] = '{msg: 7'h01, cw: 11'h013};
    vecs[3] = '{msg: 7'h7F, cw: 11'h7FC};
    vecs[4] = '{msg: 7'h2A, cw: 11'h2A3};

    rst = 1'b1; msg_valid = 1'b0; msg_data = '0; cw_ready = 1'b0;
`ifdef ERR_INJECT_EN
    inj_mask = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_msg_ready", 32'(msg_ready), 1);
    check("rst_cw_valid", 32'(cw_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cw_data", 32'(cw_data), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i].msg, vecs[i].cw, $sformatf("vec%0d", i));

    // Backpressure: data stable for 20 cycles, then exactly one transfer.
    send(7'h55);
    lat = 0;
    while (!cw_valid && lat < 30) begin @(negedge clk); lat++; end
    cap = cw_data;
    check("bp_cw", 32'(cap), 32'(encode(7'h55)));
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!cw_valid || cw_data !== cap) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 1);
    cw_ready = 1'b1;
    xfers = 0;
    repeat (5) begin
      if (cw_valid && cw_ready) xfers++;
      @(negedge clk);
    end
    cw_ready = 1'b0;
    check("bp_single_xfer", 32'(xfers), 1);

    // cw_ready asserted before cw_valid is simply ignored.
    cw_ready = 1'b1;
    send(7'h01);
    lat = 0;
    while (!cw_valid && lat < 30) begin @(negedge clk); lat++; end
    check("early_rdy_lat", 32'(lat), 7);
    check("early_rdy_cw", 32'(cw_data), 32'h013);
    @(negedge clk);
    check("early_rdy_done", 32'(cw_valid), 0);

    // msg_valid held high: accepts only in IDLE, 9 cycles apart.
    msg_valid = 1'b1;
    msg_data  = 7'h40;
    acc = 0;
    for (int k = 0; k < 18; k++) begin
      if (msg_ready) acc++;
      @(negedge clk);
    end
    msg_valid = 1'b0;
    check("held_valid_accepts", 32'(acc), 2);
    check("held_valid_idle", 32'(msg_ready), 1);
    cw_ready = 1'b0;

    // Reset in SHIFT at cnt=3.
    send(7'h7F);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_shift_valid", 32'(cw_valid), 0);
    check("rst_shift_ready", 32'(msg_ready), 1);
    check("rst_shift_busy", 32'(busy), 0);
    check("rst_shift_data", 32'(cw_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(7'h40, 11'h409, "post_rst");

    // Reset while holding a codeword in OUT.
    send(7'h33);
    lat = 0;
    while (!cw_valid && lat < 30) begin @(negedge clk); lat++; end
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(cw_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef ERR_INJECT_EN
    inj_mask = 11'h001;
    run_vec(7'h40, 11'h408, "inject");
`endif

    // All 128 messages, random gaps and random backpressure, checked in order.
    idx = 0; rx = 0; cyc = 0;
    while (rx < 128 && cyc < 20000) begin
      msg_valid = (idx < 128) && ($urandom_range(3) != 0);
      msg_data  = msg_valid ? 7'(idx) : 7'($urandom);
      cw_ready  = 1'($urandom_range(1));
      if (msg_valid && msg_ready) begin
        exp_q.push_back(7'(idx));
        idx++;
      end
      if (cw_valid && cw_ready) begin
        if (exp_q.size() == 0) begin
          check("exh_unexpected_cw", 32'(cw_data), 0);
        end else begin
          em = exp_q.pop_front();
          check($sformatf("exh_cw_%0h", em), 32'(cw_data), 32'(encode(em)));
          check($sformatf("exh_syn_%0h", em), 32'(syndrome(cw_data)), 0);
        end
        rx++;
      end
      @(negedge clk);
      cyc++;
    end
    msg_valid = 1'b0;
    cw_ready  = 1'b0;
    check("exh_count", 32'(rx), 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
